// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter: FSM states and the grant identity
// used by the round-robin tie-break.
package cache_arbiter_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/cache_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the
// requester that was not served last wins.
module rr_pick2
  import cache_arbiter_types::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic gnt_valid,
  output logic grant
);

  // Pure combinational selection; grant is meaningful only with gnt_valid.
  always_comb begin
    gnt_valid = req_i | req_d;
    grant     = GNT_I;
    if (req_d && !req_i) begin
      grant = GNT_D;
    end else if (req_d && req_i) begin
      grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates one shared physical-memory port between an icache (fill only)
// and a dcache (fill or writeback). One transaction at a time; the winner's
// address/op/data are latched at grant so the memory side never sees the
// requester's live inputs.
module cache_arbiter
  import cache_arbiter_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic              arb_err
);

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [LINE_W-1:0] lat_wdata_q;
  logic              lat_write_q;
  logic              arb_err_q;

  logic              d_pend;
  logic              gnt_valid;
  logic              grant;

  // A simultaneous read+write from the dcache is treated as a write.
  assign d_pend = d_read | d_write;

  rr_pick2 u_pick (
    .req_i      (i_read),
    .req_d      (d_pend),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .grant      (grant)
  );

  // Memory side is driven only from the latched copies.
  assign pmem_address = lat_addr_q;
  assign pmem_wdata   = lat_wdata_q;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;
  assign arb_err      = arb_err_q;

  // Next-state and outputs; responses are a combinational echo of pmem_resp
  // while serving, and everything is quiet while reset is held.
  always_comb begin
    state_d    = state_q;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = (grant == GNT_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        pmem_read  = ~lat_write_q;
        pmem_write = lat_write_q;
        if (pmem_resp) begin
          i_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      SERVE_D: begin
        pmem_read  = ~lat_write_q;
        pmem_write = lat_write_q;
        if (pmem_resp) begin
          d_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      i_resp     = 1'b0;
      d_resp     = 1'b0;
    end
  end

  // State, round-robin history, sticky error and the grant latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      arb_err_q    <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      lat_write_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (d_read && d_write) begin
        arb_err_q <= 1'b1;
      end
      if (state_q == IDLE && gnt_valid) begin
        if (grant == GNT_D) begin
          lat_addr_q  <= d_address;
          lat_wdata_q <= d_wdata;
          lat_write_q <= d_write;
        end else begin
          lat_addr_q  <= i_address;
          lat_wdata_q <= '0;
          lat_write_q <= 1'b0;
        end
      end
      if (state_q == SERVE_I && pmem_resp) begin
        last_grant_q <= GNT_I;
      end else if (state_q == SERVE_D && pmem_resp) begin
        last_grant_q <= GNT_D;
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single requests, tie alternation,
// reset abandonment and the read+write error flag.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic          i_resp;
  logic [LW-1:0] i_rdata;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic          d_resp;
  logic [LW-1:0] d_rdata;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;
  logic          arb_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [LW-1:0] pat_a5;
  logic [LW-1:0] pat_rd1;
  logic [LW-1:0] pat_rd2;
  logic [LW-1:0] pat_wd;

  logic          op_prev   = 1'b0;
  logic [AW-1:0] addr_prev = '0;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_resp       (i_resp),
    .i_rdata      (i_rdata),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_resp       (d_resp),
    .d_rdata      (d_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .arb_err      (arb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Protocol invariants sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(pmem_read && pmem_write)) else begin
        miscompares++;
        $error("FAIL inv_rw: pmem_read and pmem_write both high");
      end
      assert (!(i_resp && d_resp)) else begin
        miscompares++;
        $error("FAIL inv_resp: i_resp and d_resp both high");
      end
      assert (!(op_prev && (pmem_read || pmem_write) && pmem_address !== addr_prev)) else begin
        miscompares++;
        $error("FAIL inv_addr: observed %0h expected %0h", pmem_address, addr_prev);
      end
    end
    op_prev   <= (pmem_read || pmem_write) && !rst;
    addr_prev <= pmem_address;
  end

  initial begin
    pat_a5  = {32{8'hA5}};
    pat_rd1 = {8{32'hDEADBEEF}};
    pat_rd2 = {8{32'h0123_4567}};
    pat_wd  = {8{32'h5A5A_0F0F}};

    rst = 1'b1; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_wdata = '0; pmem_resp = 1'b0; pmem_rdata = '0;

    // Reset state
    tick(); tick();
    #1;
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_arb_err", arb_err, 1'b0);
    rst = 1'b0;
    tick();
    #1;
    chk("post_rst_idle_read", pmem_read, 1'b0);
    chk("post_rst_idle_iresp", i_resp, 1'b0);

    // icache read, memory latency 3
    i_read = 1'b1; i_address = 32'h0000_0060;
    tick();
    #1;
    chk("i_c1_read", pmem_read, 1'b1);
    chk("i_c1_write", pmem_write, 1'b0);
    chk("i_c1_addr", pmem_address, 32'h60);
    chk("i_c1_iresp", i_resp, 1'b0);
    tick();
    #1;
    chk("i_c2_read", pmem_read, 1'b1);
    chk("i_c2_addr", pmem_address, 32'h60);
    tick();
    pmem_resp = 1'b1; pmem_rdata = pat_rd1;
    #1;
    chk("i_c3_read", pmem_read, 1'b1);
    chk("i_c3_iresp", i_resp, 1'b1);
    chk("i_c3_rdata", i_rdata, pat_rd1);
    chk("i_c3_dresp", d_resp, 1'b0);
    tick();
    i_read = 1'b0;
    #1;
    // stray pmem_resp while idle must be ignored
    chk("i_idle_read", pmem_read, 1'b0);
    chk("idle_stray_iresp", i_resp, 1'b0);
    chk("idle_stray_dresp", d_resp, 1'b0);
    chk("idle_rdata_pass", d_rdata, pat_rd1);
    pmem_resp = 1'b0;
    tick();

    // dcache write, memory latency 1
    d_write = 1'b1; d_address = 32'h0000_1000; d_wdata = pat_a5;
    tick();
    pmem_resp = 1'b1; pmem_rdata = '0;
    #1;
    chk("dw_write", pmem_write, 1'b1);
    chk("dw_read", pmem_read, 1'b0);
    chk("dw_addr", pmem_address, 32'h1000);
    chk("dw_wdata", pmem_wdata, pat_a5);
    chk("dw_dresp", d_resp, 1'b1);
    chk("dw_iresp", i_resp, 1'b0);
    tick();
    d_write = 1'b0; pmem_resp = 1'b0;
    #1;
    chk("dw_idle_write", pmem_write, 1'b0);
    chk("dw_idle_dresp", d_resp, 1'b0);

    // Ties after reset: D, I, D
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_read = 1'b1; i_address = 32'h0000_0100;
    d_read = 1'b1; d_address = 32'h0000_0200;
    tick();
    pmem_resp = 1'b1; pmem_rdata = pat_rd2;
    #1;
    chk("tie1_addr", pmem_address, 32'h200);
    chk("tie1_dresp", d_resp, 1'b1);
    chk("tie1_iresp", i_resp, 1'b0);
    chk("tie1_drdata", d_rdata, pat_rd2);
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("tie1_gap_read", pmem_read, 1'b0);
    tick();
    pmem_resp = 1'b1; pmem_rdata = pat_rd1;
    #1;
    chk("tie2_addr", pmem_address, 32'h100);
    chk("tie2_iresp", i_resp, 1'b1);
    chk("tie2_dresp", d_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("tie2_gap_read", pmem_read, 1'b0);
    tick();
    pmem_resp = 1'b1;
    #1;
    chk("tie3_addr", pmem_address, 32'h200);
    chk("tie3_dresp", d_resp, 1'b1);
    chk("tie3_iresp", i_resp, 1'b0);
    tick();
    pmem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
    tick();

    // Reset during SERVE_I abandons the transaction
    i_read = 1'b1; i_address = 32'h0000_0440;
    tick();
    #1;
    chk("rs_read", pmem_read, 1'b1);
    chk("rs_addr", pmem_address, 32'h440);
    rst = 1'b1; i_read = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rs_after_read", pmem_read, 1'b0);
    chk("rs_after_addr", pmem_address, 0);
    pmem_resp = 1'b1;
    #1;
    chk("rs_stray_iresp", i_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("rs_idle_read", pmem_read, 1'b0);

    // d_read and d_write together: error flag, write issued
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0300; d_wdata = pat_wd;
    #1;
    chk("err_before", arb_err, 1'b0);
    tick();
    #1;
    chk("err_set", arb_err, 1'b1);
    chk("err_write", pmem_write, 1'b1);
    chk("err_read", pmem_read, 1'b0);
    chk("err_wdata", pmem_wdata, pat_wd);
    pmem_resp = 1'b1;
    #1;
    chk("err_dresp", d_resp, 1'b1);
    tick();
    d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    tick();
    #1;
    chk("err_sticky", arb_err, 1'b1);
    chk("err_idle_write", pmem_write, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("err_cleared", arb_err, 1'b0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache-line width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports i_read input 1, i_address input ADDR_W: icache line-fill request; held until i_resp.
REQ-006 SHALL have ports i_resp output 1, i_rdata output LINE_W: icache completion pulse and fill data.
REQ-007 SHALL have ports d_read input 1, d_write input 1, d_address input ADDR_W, d_wdata input LINE_W: dcache fill/writeback request; held until d_resp.
REQ-008 SHALL have ports d_resp output 1, d_rdata output LINE_W: dcache completion pulse and fill data.
REQ-009 SHALL have ports pmem_read output 1, pmem_write output 1, pmem_address output ADDR_W, pmem_wdata output LINE_W: single shared physical-memory port.
REQ-010 SHALL have ports pmem_resp input 1, pmem_rdata input LINE_W: memory completion pulse and read data.
REQ-011 SHALL have port arb_err output 1: sticky flag, set when d_read and d_write are both high at a sampling edge.

Function
REQ-012 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-013 IDLE: sample requests each edge; only i pending -> SERVE_I; only d pending -> SERVE_D; none -> stay.
REQ-014 Both pending in IDLE -> grant the requester not served last (last_grant register, reset value = I, so dcache wins first tie).
REQ-015 On grant, SHALL latch address, op (read/write) and wdata of the winner; pmem_* driven only from latched copies.
REQ-016 SERVE_x: pmem_read or pmem_write high (per latched op) every cycle until pmem_resp; never both high.
REQ-017 pmem_resp in SERVE_x SHALL combinationally assert x_resp in the same cycle, with x_rdata = pmem_rdata; next edge -> IDLE and last_grant updated.
REQ-018 Non-granted x_resp SHALL be 0; x_rdata when x_resp low is don't-care but SHALL be pmem_rdata passthrough (no mux to zero).
REQ-019 Latency: request high at edge k -> pmem op visible after edge k+1; minimum request-to-resp = 2 cycles with 1-cycle memory.
REQ-020 IDLE SHALL last at least one cycle between transactions; back-to-back grants alternate when both stay pending.
REQ-021 pmem_resp in IDLE SHALL be ignored (no x_resp).
REQ-022 d_read && d_write: arb_err set; request treated as write.
REQ-023 Request dropped before resp: violation, no recovery requirement; the arbiter SHALL still finish the memory transaction.

Reset
REQ-024 rst at edge -> state IDLE, last_grant = I, arb_err = 0, latched address/data = 0.
REQ-025 During rst cycle and following cycle in IDLE: pmem_read = pmem_write = 0, i_resp = d_resp = 0.
REQ-026 rst mid-SERVE SHALL abandon the transaction; a later stray pmem_resp is ignored per REQ-021.

Structure
REQ-027 FSM state enum and grant enum SHALL live in shared package cache_arbiter_types.
REQ-028 Round-robin tie-break MAY be a sub-module rr_pick2 (two requests, last_grant in, grant out); otherwise single module.
REQ-029 Implementation SHALL be synthesizable, no latches, one always_ff for state/latches.

Verification
REQ-030 Scenario: i_read, addr 0x0000_0060, mem latency 3 -> pmem_read with address 0x60 for 3 cycles, i_resp pulses once with rdata, d_resp stays 0.
REQ-031 Scenario: d_write to 0x0000_1000, wdata pattern 0xA5.. -> pmem_write with matching address/wdata, pmem_read 0, d_resp once.
REQ-032 Scenario: i_read and d_read both raised same cycle after reset -> dcache served first, then icache; 3 consecutive ties -> D, I, D.
REQ-033 Scenario: rst asserted during SERVE_I, then pmem_resp pulse -> no i_resp, state IDLE, pmem_read 0.
REQ-034 Scenario: d_read and d_write both high -> arb_err 1 and held after; write issued.
REQ-035 Assertions throughout: never pmem_read && pmem_write; never i_resp && d_resp; pmem_address stable while op high.
